alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (supported range 8..64, even).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  EX-stage instruction valid, sampled every cycle.
REQ-005 aluop  input  2  00 add, 01 sub, 10 decode funct, 11 slt.
REQ-006 funct  input  6  R-type function field.
REQ-007 a, b  input  WIDTH  operands (rs, rt/imm).
REQ-008 result  output  WIDTH  combinational single-cycle result.
REQ-009 zero  output  1  result == 0.
REQ-010 busy  output  1  multiply/divide in progress.
REQ-011 stall  output  1  pipeline must hold EX this cycle.
REQ-012 illegal  output  1  undecodable funct with en high.

Function
REQ-013 aluop 10 decode SHALL be: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt (signed), 101011 sltu, 010000 mfhi, 010010 mflo, 011000 mult, 011001 multu, 011010 div, 011011 divu.
REQ-014 Add/sub SHALL wrap modulo 2^WIDTH; no overflow trap.
REQ-015 slt/sltu SHALL return 1 or 0 zero-extended to WIDTH.
REQ-016 Undecoded funct with en=1 SHALL drive result=0, illegal=1, no state change.
REQ-017 Mul/div opcodes SHALL drive result=0; HI/LO are the only architectural output.
REQ-018 FSM states IDLE, MUL, DIV; IDLE->MUL/DIV when en & muldiv op & !stall; return IDLE after the final iteration.
REQ-019 Issue in cycle N SHALL set busy cycles N+1..N+WIDTH and write HI/LO on the clock edge ending cycle N+WIDTH.
REQ-020 Iteration SHALL be one shift-add/shift-subtract step per cycle on operand magnitudes, sign-corrected at the final write for signed ops.
REQ-021 mult/multu: {HI,LO} = full 2*WIDTH product.
REQ-022 div/divu: LO = quotient (truncated toward zero), HI = remainder (sign of dividend).
REQ-023 Divide by zero: LO = all ones, HI = a; same latency.
REQ-024 stall SHALL equal busy & en & (mfhi | mflo | muldiv op); ALU ops proceed without stall while busy.
REQ-025 mfhi/mflo in the HI/LO write cycle SHALL stall; the following cycle returns the new value.
REQ-026 Operands SHALL be latched at issue; later a/b changes do not affect the operation.

Reset
REQ-027 reset SHALL force IDLE, counter=0, HI=LO=0, busy=0 immediately, independent of clk.
REQ-028 reset mid-operation SHALL abort; no partial HI/LO write.
REQ-029 During reset stall=0; result/zero/illegal follow combinational decode.

Configuration
REQ-030 Macro ALU_EXEC_DIV_EN defined: div/divu implemented per REQ-022/023.
REQ-031 Macro undefined: div/divu treated as undecoded (REQ-016); DIV state and divider logic absent.

Structure
REQ-032 Package alu_pkg SHALL hold aluop codes, funct constants, internal alucontrol enum and FSM state enum.
REQ-033 Iterative engine SHALL be sub-module muldiv_seq (FSM, counter, HI/LO); alu_exec_unit holds decode and combinational ALU.

Verification
REQ-034 WIDTH=32, aluop=10, funct=100010, a=5, b=7 -> result=32'hFFFFFFFE, zero=0, illegal=0.
REQ-035 mult a=-3, b=5 issued cycle N -> busy N+1..N+32, then mflo=32'hFFFFFFF1, mfhi=32'hFFFFFFFF.
REQ-036 div a=-7, b=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; divu a=7, b=0 -> LO=32'hFFFFFFFF, HI=7.
REQ-037 mfhi issued cycle N+3 of a mult -> stall=1 through N+32, correct HI at N+33; add in N+3 -> no stall.
REQ-038 reset pulse at cycle N+10 of a multu -> busy=0, HI=LO=0 immediately, next mflo returns 0.
REQ-039 Build without ALU_EXEC_DIV_EN, div issued -> illegal=1, busy stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the EX-stage ALU and its mul/div engine.
// Build option: define ALU_EXEC_DIV_EN to include the iterative divider.
package alu_pkg;

  typedef enum logic [1:0] {
    AOP_ADD   = 2'b00,
    AOP_SUB   = 2'b01,
    AOP_FUNCT = 2'b10,
    AOP_SLT   = 2'b11
  } aluop_e;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_MFHI,
    ALU_MFLO,
    ALU_MULT,
    ALU_MULTU,
    ALU_DIV,
    ALU_DIVU,
    ALU_BAD
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL
`ifdef ALU_EXEC_DIV_EN
    ,
    DIV
`endif
  } md_state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative one-bit-per-cycle multiply/divide engine owning HI/LO.
// Build option: ALU_EXEC_DIV_EN adds the restoring divider and DIV state.
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef ALU_EXEC_DIV_EN
  input  logic             div,
`endif
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_e          state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   opb;
  logic               neg_q;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     msum;
  logic [WIDTH-1:0]   mul_hi;
  logic [WIDTH-1:0]   mul_lo;
  logic [2*WIDTH-1:0] prod;
`ifdef ALU_EXEC_DIV_EN
  logic               neg_r;
  logic               dz;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH:0]     shl;
  logic               ge;
  logic [WIDTH-1:0]   div_hi;
  logic [WIDTH-1:0]   div_lo;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
`endif

  assign mag_a = (sgn & a[WIDTH-1]) ? -a : a;
  assign mag_b = (sgn & b[WIDTH-1]) ? -b : b;

  // One shift-add step; product sign applied on the final write
  always_comb begin
    msum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    mul_hi = msum[WIDTH:1];
    mul_lo = {msum[0], acc_lo[WIDTH-1:1]};
    prod = neg_q ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};
  end

`ifdef ALU_EXEC_DIV_EN
  // One restoring shift-subtract step plus final sign correction
  always_comb begin
    shl = {acc_hi, acc_lo[WIDTH-1]};
    ge = shl >= {1'b0, opb};
    div_hi = ge ? (shl[WIDTH-1:0] - opb) : shl[WIDTH-1:0];
    div_lo = {acc_lo[WIDTH-2:0], ge};
    quo = neg_q ? -div_lo : div_lo;
    rem = neg_r ? -div_hi : div_hi;
  end
`endif

  // Sequencer: latch operands at issue, iterate WIDTH times, commit HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      neg_q  <= 1'b0;
`ifdef ALU_EXEC_DIV_EN
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      a_raw  <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc_hi <= '0;
            acc_lo <= mag_a;
            opb    <= mag_b;
            cnt    <= '0;
            busy   <= 1'b1;
            neg_q  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_EXEC_DIV_EN
            neg_r  <= sgn & a[WIDTH-1];
            dz     <= (b == '0);
            a_raw  <= a;
            state  <= div ? DIV : MUL;
`else
            state  <= MUL;
`endif
          end
        end
        MUL: begin
          acc_hi <= mul_hi;
          acc_lo <= mul_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            {hi, lo} <= prod;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
`ifdef ALU_EXEC_DIV_EN
        DIV: begin
          acc_hi <= div_hi;
          acc_lo <= div_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            hi    <= dz ? a_raw : rem;
            lo    <= dz ? '1 : quo;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
`endif
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: funct decode, single-cycle ALU, stall and mul/div issue.
// Build option: ALU_EXEC_DIV_EN enables div/divu (else they decode illegal).
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             stall,
  output logic             illegal
);

  alu_ctrl_e        ctrl;
  logic             md_op;
  logic             hilo_op;
  logic             md_sgn;
  logic             start;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef ALU_EXEC_DIV_EN
  logic             md_div;
`endif

  // Collapse aluop/funct into one internal operation
  always_comb begin
    ctrl = ALU_BAD;
    unique case (aluop)
      AOP_ADD: ctrl = ALU_ADD;
      AOP_SUB: ctrl = ALU_SUB;
      AOP_SLT: ctrl = ALU_SLT;
      default: begin
        unique case (funct)
          F_ADD:   ctrl = ALU_ADD;
          F_SUB:   ctrl = ALU_SUB;
          F_AND:   ctrl = ALU_AND;
          F_OR:    ctrl = ALU_OR;
          F_XOR:   ctrl = ALU_XOR;
          F_NOR:   ctrl = ALU_NOR;
          F_SLT:   ctrl = ALU_SLT;
          F_SLTU:  ctrl = ALU_SLTU;
          F_MFHI:  ctrl = ALU_MFHI;
          F_MFLO:  ctrl = ALU_MFLO;
          F_MULT:  ctrl = ALU_MULT;
          F_MULTU: ctrl = ALU_MULTU;
`ifdef ALU_EXEC_DIV_EN
          F_DIV:   ctrl = ALU_DIV;
          F_DIVU:  ctrl = ALU_DIVU;
`endif
          default: ctrl = ALU_BAD;
        endcase
      end
    endcase
  end

`ifdef ALU_EXEC_DIV_EN
  assign md_div = (ctrl == ALU_DIV) | (ctrl == ALU_DIVU);
  assign md_op  = (ctrl == ALU_MULT) | (ctrl == ALU_MULTU) | md_div;
  assign md_sgn = (ctrl == ALU_MULT) | (ctrl == ALU_DIV);
`else
  assign md_op  = (ctrl == ALU_MULT) | (ctrl == ALU_MULTU);
  assign md_sgn = (ctrl == ALU_MULT);
`endif

  assign hilo_op = (ctrl == ALU_MFHI) | (ctrl == ALU_MFLO);
  assign stall   = busy & en & (md_op | hilo_op);
  assign start   = en & md_op & ~stall;
  assign illegal = en & (ctrl == ALU_BAD);

  // Single-cycle result; mul/div and undecoded ops produce zero
  always_comb begin
    result = '0;
    unique case (ctrl)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, a < b};
      ALU_MFHI: result = hi;
      ALU_MFLO: result = lo;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

  muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (start),
`ifdef ALU_EXEC_DIV_EN
    .div   (md_div),
`endif
    .sgn   (md_sgn),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (WIDTH=32).
// Div checks follow ALU_EXEC_DIV_EN; otherwise div must decode illegal.
module tb_alu_exec_unit;

  localparam int W = 32;

  localparam logic [5:0] FADD   = 6'h20;
  localparam logic [5:0] FSUB   = 6'h22;
  localparam logic [5:0] FAND   = 6'h24;
  localparam logic [5:0] FOR    = 6'h25;
  localparam logic [5:0] FXOR   = 6'h26;
  localparam logic [5:0] FNOR   = 6'h27;
  localparam logic [5:0] FSLT   = 6'h2a;
  localparam logic [5:0] FSLTU  = 6'h2b;
  localparam logic [5:0] FMFHI  = 6'h10;
  localparam logic [5:0] FMFLO  = 6'h12;
  localparam logic [5:0] FMULT  = 6'h18;
  localparam logic [5:0] FMULTU = 6'h19;
  localparam logic [5:0] FDIV   = 6'h1a;
  localparam logic [5:0] FDIVU  = 6'h1b;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [1:0]   aluop;
  logic [5:0]   funct;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;
  logic         stall;
  logic         illegal;

  int ncomp = 0;
  int nfail = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  logic [5:0] legal [10] = '{FADD, FSUB, FAND, FOR, FXOR,
                             FNOR, FSLT, FSLTU, FMFHI, FMFLO};

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .aluop   (aluop),
    .funct   (funct),
    .a       (a),
    .b       (b),
    .result  (result),
    .zero    (zero),
    .busy    (busy),
    .stall   (stall),
    .illegal (illegal)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    ncomp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [1:0] op,
                       input logic [5:0] f, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    en = e;
    aluop = op;
    funct = f;
    a = x;
    b = y;
    #1;
  endtask

  function automatic logic known(input logic [5:0] f);
    return f inside {FADD, FSUB, FAND, FOR, FXOR, FNOR, FSLT, FSLTU,
                     FMFHI, FMFLO, FMULT, FMULTU, FDIV, FDIVU};
  endfunction

  task automatic alu_ref(input logic [1:0] op, input logic [5:0] f,
                         input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic ill);
    ill = 1'b0;
    r = '0;
    case (op)
      2'b00: r = x + y;
      2'b01: r = x - y;
      2'b11: r = ($signed(x) < $signed(y)) ? 1 : 0;
      default: begin
        case (f)
          FADD:  r = x + y;
          FSUB:  r = x - y;
          FAND:  r = x & y;
          FOR:   r = x | y;
          FXOR:  r = x ^ y;
          FNOR:  r = ~(x | y);
          FSLT:  r = ($signed(x) < $signed(y)) ? 1 : 0;
          FSLTU: r = (x < y) ? 1 : 0;
          FMFHI: r = m_hi;
          FMFLO: r = m_lo;
          FMULT, FMULTU: r = '0;
`ifdef ALU_EXEC_DIV_EN
          FDIV, FDIVU: r = '0;
`endif
          default: ill = 1'b1;
        endcase
      end
    endcase
  endtask

  task automatic md_ref(input logic [5:0] f, input logic [W-1:0] x,
                        input logic [W-1:0] y, output logic [W-1:0] eh,
                        output logic [W-1:0] el);
    longint sx = $signed(x);
    longint sy = $signed(y);
    longint unsigned ux = x;
    longint unsigned uy = y;
    longint sp;
    longint unsigned up;
    eh = '0;
    el = '0;
    case (f)
      FMULT: begin
        sp = sx * sy;
        {eh, el} = sp;
      end
      FMULTU: begin
        up = ux * uy;
        {eh, el} = up;
      end
      FDIV: begin
        if (y == '0) begin
          el = '1;
          eh = x;
        end else begin
          sp = sx / sy;
          el = sp[W-1:0];
          sp = sx % sy;
          eh = sp[W-1:0];
        end
      end
      default: begin
        if (y == '0) begin
          el = '1;
          eh = x;
        end else begin
          up = ux / uy;
          el = up[W-1:0];
          up = ux % uy;
          eh = up[W-1:0];
        end
      end
    endcase
  endtask

  task automatic run_md(input string tag, input logic [5:0] f,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
    int n;
    cyc();
    drive(1'b1, 2'b10, f, x, y);
    check({tag, "_issue_stall"}, stall, 0);
    check({tag, "_issue_res"}, result, 0);
    check({tag, "_issue_ill"}, illegal, 0);
    n = 0;
    cyc();
    drive(1'b0, 2'b00, 6'h0, $urandom, $urandom);
    while (busy === 1'b1 && n < W + 8) begin
      n++;
      cyc();
      drive(1'b0, 2'b00, 6'h0, $urandom, $urandom);
    end
    check({tag, "_latency"}, n, W);
    drive(1'b1, 2'b10, FMFLO, $urandom, $urandom);
    check({tag, "_lo"}, result, el);
    cyc();
    drive(1'b1, 2'b10, FMFHI, $urandom, $urandom);
    check({tag, "_hi"}, result, eh);
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] x, y, er, eh, el;
    logic [1:0]   op;
    logic [5:0]   f;
    logic         ei;
    int           k;

    reset = 1'b1;
    drive(1'b1, 2'b10, FMFHI, '0, '0);
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    check("rst_hi", result, 0);
    check("rst_zero", zero, 1);
    drive(1'b1, 2'b10, FMFLO, '0, '0);
    check("rst_lo", result, 0);
    repeat (2) cyc();
    reset = 1'b0;

    cyc();
    drive(1'b1, 2'b10, FSUB, 32'd5, 32'd7);
    check("sub_res", result, 32'hFFFFFFFE);
    check("sub_zero", zero, 0);
    check("sub_ill", illegal, 0);

    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      f = 6'($urandom);
      if (op == 2'b10) begin
        k = $urandom_range(0, 11);
        if (k < 10) f = legal[k];
        else begin
          do f = 6'($urandom); while (known(f));
        end
      end
      x = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
      y = ($urandom_range(0, 3) == 0) ? x : $urandom;
      cyc();
      drive(1'b1, op, f, x, y);
      alu_ref(op, f, x, y, er, ei);
      check("alu_res", result, er);
      check("alu_zero", zero, (er == '0));
      check("alu_ill", illegal, ei);
      check("alu_stall", stall, 0);
    end

    cyc();
    drive(1'b1, 2'b10, FMULT, 32'hFFFFFFFD, 32'd5);
    check("m35_issue_stall", stall, 0);
    for (int i = 1; i <= W; i++) begin
      cyc();
      if (i == 3) begin
        drive(1'b1, 2'b00, 6'h0, 32'd100, 32'd23);
        check("m35_add_stall", stall, 0);
        check("m35_add_res", result, 123);
      end else begin
        drive(1'b0, 2'b00, 6'h0, $urandom, $urandom);
      end
      check("m35_busy", busy, 1);
    end
    cyc();
    drive(1'b1, 2'b10, FMFLO, '0, '0);
    check("m35_busy_done", busy, 0);
    check("m35_lo", result, 32'hFFFFFFF1);
    cyc();
    drive(1'b1, 2'b10, FMFHI, '0, '0);
    check("m35_hi", result, 32'hFFFFFFFF);
    m_hi = 32'hFFFFFFFF;
    m_lo = 32'hFFFFFFF1;

    x = $urandom;
    y = $urandom;
    md_ref(FMULT, x, y, eh, el);
    cyc();
    drive(1'b1, 2'b10, FMULT, x, y);
    check("m37_issue_stall", stall, 0);
    for (int i = 1; i <= 2; i++) begin
      cyc();
      drive(1'b0, 2'b00, 6'h0, $urandom, $urandom);
    end
    for (int i = 3; i <= W; i++) begin
      cyc();
      drive(1'b1, 2'b10, FMFHI, $urandom, $urandom);
      check("m37_mfhi_stall", stall, 1);
    end
    cyc();
    drive(1'b1, 2'b10, FMFHI, $urandom, $urandom);
    check("m37_release", stall, 0);
    check("m37_hi", result, eh);
    cyc();
    drive(1'b1, 2'b10, FMFLO, $urandom, $urandom);
    check("m37_lo", result, el);
    m_hi = eh;
    m_lo = el;

    for (int i = 0; i < 24; i++) begin
`ifdef ALU_EXEC_DIV_EN
      k = $urandom_range(0, 3);
`else
      k = $urandom_range(0, 1);
`endif
      f = (k == 0) ? FMULT : (k == 1) ? FMULTU : (k == 2) ? FDIV : FDIVU;
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 3) == 0) y = -y;
      if (k >= 2 && $urandom_range(0, 7) == 0) y = '0;
      md_ref(f, x, y, eh, el);
      run_md("md_rand", f, x, y, eh, el);
    end

`ifdef ALU_EXEC_DIV_EN
    run_md("div_neg", FDIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("divu_zero", FDIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
    run_md("div_zero_s", FDIV, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0,
           32'hFFFFFFFF);
    run_md("div_ovf", FDIV, 32'h80000000, 32'hFFFFFFFF, 32'h0,
           32'h80000000);
`else
    cyc();
    drive(1'b1, 2'b10, FDIV, 32'hFFFFFFF9, 32'd2);
    check("nodiv_ill", illegal, 1);
    check("nodiv_res", result, 0);
    check("nodiv_stall", stall, 0);
    cyc();
    drive(1'b1, 2'b10, FDIVU, 32'd7, 32'd0);
    check("nodivu_ill", illegal, 1);
    check("nodiv_busy", busy, 0);
    cyc();
    drive(1'b0, 2'b10, FMFHI, '0, '0);
    check("nodiv_busy2", busy, 0);
    check("nodiv_hi", result, m_hi);
    cyc();
    drive(1'b0, 2'b10, FMFLO, '0, '0);
    check("nodiv_lo", result, m_lo);
`endif

    x = $urandom | 32'h1;
    y = $urandom | 32'h1;
    cyc();
    drive(1'b1, 2'b10, FMULTU, x, y);
    for (int i = 1; i <= 9; i++) begin
      cyc();
      drive(1'b0, 2'b00, 6'h0, $urandom, $urandom);
    end
    cyc();
    drive(1'b1, 2'b10, FMFLO, '0, '0);
    check("rmid_stall_pre", stall, 1);
    #2;
    reset = 1'b1;
    #1;
    check("rmid_busy", busy, 0);
    check("rmid_stall", stall, 0);
    check("rmid_lo", result, 0);
    check("rmid_zero", zero, 1);
    m_hi = '0;
    m_lo = '0;
    reset = 1'b0;
    #1;
    cyc();
    drive(1'b1, 2'b10, FMFLO, '0, '0);
    check("rpost_lo", result, 0);
    check("rpost_busy", busy, 0);
    cyc();
    drive(1'b1, 2'b10, FMFHI, '0, '0);
    check("rpost_hi", result, 0);
    cyc();
    drive(1'b0, 2'b00, 6'h0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
